sequential_multiplier: RTL
==========================

Name: sequential_multiplier

Overview:
Unsigned radix-2 shift-add multiplier. It is the inverse-operation companion of the sequential divider and uses the same start/ready/done handshake. It takes two WIDTH-bit operands and produces a 2*WIDTH-bit product in a fixed WIDTH+1 cycles. The block contains a small control FSM and a datapath with accumulator, shifted multiplicand and shifting multiplier registers.

Parameters:
WIDTH, 8, operand width in bits; legal range WIDTH >= 2; product width is 2*WIDTH.

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous, active-high reset
start  input  1  request; sampled only while ready=1
a  input  WIDTH  multiplicand, captured when start is accepted
b  input  WIDTH  multiplier, captured when start is accepted
ready  output  1  high only in IDLE; the block can accept start
done  output  1  one-cycle pulse; product is valid
product  output  2*WIDTH  result register; held until the next accepted start

Behaviour:
- Reset (asynchronous, active-high):
  - State goes to IDLE; product, accumulator, multiplicand, multiplier and counter clear to 0.
  - Outputs during and after reset: done=0, ready=1.
- States:
  - IDLE: ready=1. If start=1 at a clock edge → OP. On that same edge: mcand <= zero-extended a (2*WIDTH bits), mplr <= b, acc <= 0, cnt <= WIDTH.
  - OP: ready=0. Each edge:
    - if mplr[0]=1 then acc <= acc + mcand;
    - mcand <= mcand << 1; mplr <= mplr >> 1; cnt <= cnt - 1.
    - When cnt == 1 on the edge → FINAL.
  - FINAL: one cycle. product <= acc. → DONE.
  - DONE: done=1 for exactly this cycle. → IDLE unconditionally.
- Latency:
  - Start is accepted on edge E0.
  - OP occupies cycles E0..E0+WIDTH, with WIDTH add/shift steps.
  - FINAL runs on cycle E0+WIDTH+1; done is high during the cycle after that.
  - Start-to-done is WIDTH+2 edges. Next start is accepted one cycle after done.
- Arithmetic:
  - acc and mcand are 2*WIDTH bits; no overflow is possible (max (2^W-1)^2 < 2^(2W)).
  - cnt is $clog2(WIDTH+1) bits; it never wraps because it stops at 1.
- Fixed latency: no early exit when mplr becomes 0.
- Boundaries:
  - start while ready=0 is ignored; operands are not recaptured.
  - start held continuously: it is re-accepted in the IDLE cycle following DONE, giving a back-to-back period of WIDTH+3 cycles.
  - a or b changing after acceptance has no effect.
  - product keeps its old value through OP, changes only on the FINAL edge, and holds afterward.
  - Reset mid-operation aborts immediately: no done pulse, product=0.
  - ready and done are decoded combinationally from the state register only, with no dependence on inputs.

Decomposition:
- Shared constants file:
  - state encoding IDLE=0, OP=1, FINAL=2, DONE=3 (2 bits);
  - select codes for the datapath: 00 hold, 01 load, 10 step, 11 commit.
- Sub-module mult_control_path:
  - inputs: clk, rst, start, cnt;
  - outputs: ready, done, sel[1:0].
- The datapath registers live in the top level (sequential_multiplier) and are driven by sel. This mirrors the divider's control/data split.

Test Plan:
- Reset then a=0x0D, b=0x0B, pulse start → ready drops next cycle; done pulses exactly 10 edges after acceptance; product=0x008F.
- a=0xFF, b=0xFF → product=0xFE01. Then a=0x00, b=0x5A → product=0x0000. Then a=0x80, b=0x01 → product=0x0080. Latency is identical in all cases.
- Hold start=1 with a=3, b=5, then change to a=7, b=9 after the first acceptance → first product=0x000F, second product=0x003F. Acceptances are 11 cycles apart, and done never overlaps ready=0 of the next operation.
- Pulse start again mid-OP with a=0x11, b=0x22 → ignored. Result equals the original operands' product, and no extra done pulse occurs.
- Assert rst asynchronously (between edges) at OP step 4 → outputs immediately go to ready=1, done=0, product=0. A new start after release (a=2, b=3) gives product=0x0006.
- Parameter sweep WIDTH=4 and WIDTH=16 with random operands against a reference model (≥1000 vectors) → product matches a*b; done arrives WIDTH+2 edges after acceptance.

Source files
------------

// File: rtl/sequential_multiplier_pkg.sv
// Shared encodings for the shift-add multiplier: FSM states and the
// datapath select codes the control path hands to the register file.
package sequential_multiplier_pkg;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_OP    = 2'd1;
  localparam logic [1:0] S_FINAL = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [1:0] SEL_HOLD   = 2'b00;
  localparam logic [1:0] SEL_LOAD   = 2'b01;
  localparam logic [1:0] SEL_STEP   = 2'b10;
  localparam logic [1:0] SEL_COMMIT = 2'b11;

endpackage

// File: rtl/sequential_multiplier_control_path.sv
// Control FSM: sequences load, WIDTH add/shift steps, commit and a done pulse.
// ready/done depend on the state register only.
module mult_control_path
  import sequential_multiplier_pkg::*;
#(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] cnt,
  output logic             ready,
  output logic             done,
  output logic [1:0]       sel
);

  logic [1:0] state, state_nxt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    sel       = SEL_HOLD;
    case (state)
      S_IDLE: if (start) begin
        state_nxt = S_OP;
        sel       = SEL_LOAD;
      end
      S_OP: begin
        sel = SEL_STEP;
        // cnt is the number of steps still to run including this one
        if (cnt == CNT_W'(1)) state_nxt = S_FINAL;
      end
      S_FINAL: begin
        sel       = SEL_COMMIT;
        state_nxt = S_DONE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  assign ready = (state == S_IDLE);
  assign done  = (state == S_DONE);

endmodule

// File: rtl/sequential_multiplier.sv
// Unsigned radix-2 shift-add multiplier, fixed WIDTH+1 cycle operation.
// Datapath registers live here and are steered by the control path's sel code.
module sequential_multiplier
  import sequential_multiplier_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               ready,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(WIDTH);

  logic [2*WIDTH-1:0] acc, mcand;
  logic [WIDTH-1:0]   mplr;
  logic [CNT_W-1:0]   cnt;
  logic [1:0]         sel;

  mult_control_path #(.CNT_W(CNT_W)) u_ctrl (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .cnt   (cnt),
    .ready (ready),
    .done  (done),
    .sel   (sel)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc     <= '0;
      mcand   <= '0;
      mplr    <= '0;
      cnt     <= '0;
      product <= '0;
    end else begin
      case (sel)
        SEL_LOAD: begin
          mcand <= {{WIDTH{1'b0}}, a};
          mplr  <= b;
          acc   <= '0;
          cnt   <= CNT_INIT;
        end
        SEL_STEP: begin
          if (mplr[0]) acc <= acc + mcand;
          mcand <= mcand << 1;
          mplr  <= mplr >> 1;
          cnt   <= cnt - 1'b1;
        end
        SEL_COMMIT: product <= acc;
        default: ;
      endcase
    end
  end

endmodule
